fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width; word addressed, so PC increments by 1.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two and at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 Port imem_req, output, 1, fetch enable to instruction memory.
REQ-008 Port imem_addr, output, ADDR_W, fetch address; equals the PC register.
REQ-009 Port imem_data, input, INST_W, instruction at imem_addr, valid combinationally in the same cycle.
REQ-010 Port redirect_valid, input, 1, branch/jump taken: flush the queue and refetch.
REQ-011 Port redirect_pc, input, ADDR_W, new fetch address; sampled when redirect_valid=1.
REQ-012 Port out_valid, output, 1, head entry available to decode.
REQ-013 Port out_ready, input, 1, decode accepts the head; low means stall.
REQ-014 Port out_inst, output, INST_W, head instruction; 0 (bubble) when out_valid=0.
REQ-015 Port out_pc, output, ADDR_W, PC of the head instruction; 0 when out_valid=0.
REQ-016 Port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-017 Port redirect_cnt, output, 16, number of redirects since reset; saturates at 0xFFFF.

Function
REQ-018 Storage is a circular buffer with a head pointer, a tail pointer and a count; each entry is an {inst, pc} pair; pointers wrap modulo DEPTH.
REQ-019 imem_req = rst_n & ~redirect_valid & (count != DEPTH); it is evaluated on registered count only, with no bypass from a same-cycle pop.
REQ-020 Push: when imem_req=1, write {imem_data, imem_addr} at the tail, advance the tail, and set PC <= PC+1; PC wraps modulo 2^ADDR_W.
REQ-021 out_valid = (count != 0) & ~redirect_valid; out_inst and out_pc show the head entry.
REQ-022 Pop: when out_valid & out_ready, advance the head.
REQ-023 Count rules: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged.
REQ-024 Latency: an instruction fetched in cycle N is first visible on out_* in cycle N+1; there is no fetch-to-output bypass.
REQ-025 Redirect has highest priority. On it, in one cycle: count, head and tail go to 0; PC <= redirect_pc; no push; no pop; redirect_cnt increments, saturating.
REQ-026 Redirect while empty still loads the PC and still counts.
REQ-027 Back-to-back redirects: each one reloads the PC; the last one wins.
REQ-028 Full with out_ready=1: the cycle pops only; the next cycle pushes.
REQ-029 Empty with out_ready=1: out_valid=0, no pop, count is not decremented.
REQ-030 out_ready has no effect when out_valid=0; redirect_pc is ignored when redirect_valid=0.
REQ-031 Steady flow (out_ready=1, no redirect) sustains one instruction per cycle with count=1.

Reset
REQ-032 While rst_n=0 at a rising edge: PC=RESET_PC, count=0, head=0, tail=0, redirect_cnt=0; entry contents are don't-care.
REQ-033 While rst_n=0: imem_req=0, out_valid=0, out_inst=0, out_pc=0.
REQ-034 Reset asserted mid-operation discards all entries and any same-cycle redirect, push or pop.
REQ-035 The first push occurs in the first cycle with rst_n=1, at address RESET_PC.

Verification (DEPTH=4, RESET_PC=0, imem_data=addr+0x100)
REQ-036 Release reset, out_ready=0 -> imem_addr 0,1,2,3 on successive cycles; count 1..4; then imem_req=0 with imem_addr held at 4; out_pc=0, out_inst=0x100.
REQ-037 Release reset, out_ready=1 -> out_pc 0,1,2,3... one per cycle starting at cycle 2; count stays 1; out_inst=out_pc+0x100.
REQ-038 count=3, redirect_valid=1, redirect_pc=0x40 -> out_valid=0 that cycle; next cycle count=0 and imem_addr=0x40; one cycle later out_pc=0x40 and out_inst=0x140; redirect_cnt=1.
REQ-039 count=4, out_ready=1 for one cycle -> count=3 with no push that cycle; next cycle a push at address 4 with count back to 4 if out_ready=0.
REQ-040 count=2, PC=7, rst_n=0 for one cycle -> count=0, imem_addr=0, out_valid=0, redirect_cnt=0.
REQ-041 65536 redirects, force-loaded, then one more -> redirect_cnt stays 0xFFFF.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a PC register drives instruction memory every cycle there
// is room, and the fetched {inst, pc} pairs are buffered in a circular queue for decode.
module fetch_queue #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INST_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic [INST_W-1:0]            imem_data,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INST_W-1:0]            out_inst,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [15:0]                  redirect_cnt
);

   localparam int                 PTR_W    = $clog2(DEPTH);
   localparam int                 CNT_W    = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_pc;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [15:0]       r_redirect_cnt;
   logic [INST_W-1:0] r_inst [DEPTH];
   logic [ADDR_W-1:0] r_ipc  [DEPTH];

   logic w_push;
   logic w_pop;
   logic w_out_valid;

   // Output handshake: an entry transfers to decode in a cycle where out_valid and
   // out_ready are both high at the rising edge; out_valid never waits on out_ready.
   // Fullness uses the registered count only, so a full queue pops first and refills
   // one cycle later.
   assign w_push      = rst_n & ~redirect_valid & (r_count != FULL_CNT);
   assign w_out_valid = rst_n & ~redirect_valid & (r_count != '0);
   assign w_pop       = w_out_valid & out_ready;

   assign imem_req     = w_push;
   assign imem_addr    = r_pc;
   assign out_valid    = w_out_valid;
   assign out_inst     = w_out_valid ? r_inst[r_head] : '0;
   assign out_pc       = w_out_valid ? r_ipc[r_head]  : '0;
   assign count        = r_count;
   assign redirect_cnt = r_redirect_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc           <= RESET_PC;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_redirect_cnt <= '0;
      end else if (redirect_valid) begin
         r_pc    <= redirect_pc;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         if (r_redirect_cnt != 16'hFFFF) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
         end
      end else begin
         if (w_push) begin
            r_inst[r_tail] <= imem_data;
            r_ipc[r_tail]  <= r_pc;
            r_tail         <= r_tail + PTR_W'(1);
            r_pc           <= r_pc + ADDR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (DEPTH=4, RESET_PC=0, imem_data = addr + 0x100): a directed
// vector table, an in-order delivery scoreboard, and redirect counter saturation.
module tb_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  count;
   logic [15:0] redirect_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic        rst_n;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  cnt;
      logic [15:0] rcnt;
   } vec_t;

   vec_t vq[$];

   fetch_queue dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .count          (count),
      .redirect_cnt   (redirect_cnt)
   );

   // instruction memory model
   assign imem_data = imem_addr + 32'h100;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      rst_n          = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                          input logic req, input logic [31:0] addr, input logic vld,
                          input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] cnt,
                          input logic [15:0] rcnt);
      vec_t v;
      v.rst_n = r;   v.rv = rv;     v.rpc = rpc;   v.rdy = rdy;
      v.req   = req; v.addr = addr; v.vld = vld;   v.inst = inst;
      v.pc    = pc;  v.cnt = cnt;   v.rcnt = rcnt;
      vq.push_back(v);
   endtask

   initial begin
      int accepted;
      int budget;
      logic [31:0] e_pc;

      //       rst rv rpc           rdy | req addr          vld inst          pc            cnt rcnt
      add_vec(0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
      add_vec(1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        32'h0,        0, 0);
      add_vec(1, 0, 32'h0,        0,   1, 32'h1,        1, 32'h100,      32'h0,        1, 0);
      add_vec(1, 0, 32'h0,        0,   1, 32'h2,        1, 32'h100,      32'h0,        2, 0);
      add_vec(1, 0, 32'h0,        0,   1, 32'h3,        1, 32'h100,      32'h0,        3, 0);
      add_vec(1, 0, 32'h0,        0,   0, 32'h4,        1, 32'h100,      32'h0,        4, 0);
      add_vec(1, 0, 32'h0,        0,   0, 32'h4,        1, 32'h100,      32'h0,        4, 0);
      add_vec(1, 0, 32'h0,        1,   0, 32'h4,        1, 32'h100,      32'h0,        4, 0);
      add_vec(1, 0, 32'h0,        0,   1, 32'h4,        1, 32'h101,      32'h1,        3, 0);
      add_vec(1, 0, 32'h0,        0,   0, 32'h5,        1, 32'h101,      32'h1,        4, 0);
      add_vec(1, 0, 32'h0,        1,   0, 32'h5,        1, 32'h101,      32'h1,        4, 0);
      add_vec(1, 0, 32'h0,        1,   1, 32'h5,        1, 32'h102,      32'h2,        3, 0);
      add_vec(1, 0, 32'h0,        1,   1, 32'h6,        1, 32'h103,      32'h3,        3, 0);
      add_vec(1, 1, 32'h40,       1,   0, 32'h7,        0, 32'h0,        32'h0,        3, 0);
      add_vec(1, 0, 32'h55,       0,   1, 32'h40,       0, 32'h0,        32'h0,        0, 1);
      add_vec(1, 0, 32'h55,       0,   1, 32'h41,       1, 32'h140,      32'h40,       1, 1);
      add_vec(1, 1, 32'h5,        0,   0, 32'h42,       0, 32'h0,        32'h0,        2, 1);
      add_vec(1, 0, 32'h0,        0,   1, 32'h5,        0, 32'h0,        32'h0,        0, 2);
      add_vec(1, 0, 32'h0,        0,   1, 32'h6,        1, 32'h105,      32'h5,        1, 2);
      add_vec(0, 1, 32'h99,       1,   0, 32'h7,        0, 32'h0,        32'h0,        2, 2);
      add_vec(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h0,        0, 0);
      add_vec(1, 0, 32'h0,        1,   1, 32'h1,        1, 32'h100,      32'h0,        1, 0);
      add_vec(1, 0, 32'h0,        1,   1, 32'h2,        1, 32'h101,      32'h1,        1, 0);
      add_vec(1, 0, 32'h0,        1,   1, 32'h3,        1, 32'h102,      32'h2,        1, 0);
      add_vec(1, 1, 32'h20,       1,   0, 32'h4,        0, 32'h0,        32'h0,        1, 0);
      add_vec(1, 1, 32'h30,       1,   0, 32'h20,       0, 32'h0,        32'h0,        0, 1);
      add_vec(1, 0, 32'h77,       1,   1, 32'h30,       0, 32'h0,        32'h0,        0, 2);
      add_vec(1, 0, 32'h77,       1,   1, 32'h31,       1, 32'h130,      32'h30,       1, 2);
      add_vec(1, 1, 32'hFFFFFFFF, 1,   0, 32'h32,       0, 32'h0,        32'h0,        1, 2);
      add_vec(1, 0, 32'h0,        0,   1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        0, 3);
      add_vec(1, 0, 32'h0,        0,   1, 32'h0,        1, 32'hFF,       32'hFFFFFFFF, 1, 3);

      // initial reset edge so the first vector sees defined state
      set_in(0, 0, 32'h0, 0);
      to_next();

      foreach (vq[i]) begin
         set_in(vq[i].rst_n, vq[i].rv, vq[i].rpc, vq[i].rdy);
         to_neg();
         chk($sformatf("v%0d imem_req", i),     {31'b0, imem_req},     {31'b0, vq[i].req});
         chk($sformatf("v%0d imem_addr", i),    imem_addr,             vq[i].addr);
         chk($sformatf("v%0d out_valid", i),    {31'b0, out_valid},    {31'b0, vq[i].vld});
         chk($sformatf("v%0d out_inst", i),     out_inst,              vq[i].inst);
         chk($sformatf("v%0d out_pc", i),       out_pc,                vq[i].pc);
         chk($sformatf("v%0d count", i),        {29'b0, count},        {29'b0, vq[i].cnt});
         chk($sformatf("v%0d redirect_cnt", i), {16'b0, redirect_cnt}, {16'b0, vq[i].rcnt});
         to_next();
      end

      // in-order delivery with stalls, then steady flow
      set_in(1, 1, 32'h200, 0);
      to_next();
      for (int k = 0; k < 160; k++) exp_q.push_back(32'h200 + k);
      accepted = 0;
      for (int i = 0; i < 150; i++) begin
         set_in(1, 0, 32'h0, (i >= 100) || (i % 3 != 0));
         to_neg();
         n_checks++;
         if (count > 3'd4) begin
            n_errors++;
            $display("FAIL sb count: got %0d expected <= 4 (cycle %0d)", count, i);
         end
         if (i >= 110) chk($sformatf("sb steady out_valid c%0d", i), {31'b0, out_valid}, 32'h1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb underflow: got pc 0x%0h expected none", out_pc);
            end else begin
               e_pc = exp_q.pop_front();
               chk("sb out_pc", out_pc, e_pc);
               chk("sb out_inst", out_inst, e_pc + 32'h100);
               accepted++;
            end
         end
         to_next();
      end
      chk("sb accepted >= 100", {31'b0, (accepted >= 100)}, 32'h1);

      // redirect counter saturation
      set_in(0, 0, 32'h0, 0);
      to_next();
      budget = 65536;
      for (int i = 0; i < budget; i++) begin
         set_in(1, 1, i, 0);
         to_next();
      end
      set_in(1, 0, 32'h0, 0);
      to_neg();
      chk("sat after 65536", {16'b0, redirect_cnt}, 32'hFFFF);
      chk("sat imem_addr", imem_addr, budget - 1);
      to_next();
      set_in(1, 1, 32'h10, 0);
      to_next();
      set_in(1, 0, 32'h0, 0);
      to_neg();
      chk("sat after one more", {16'b0, redirect_cnt}, 32'hFFFF);
      chk("sat reload pc", imem_addr, 32'h10);
      to_next();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
